// File: rtl/lc3_mem_sys.sv
// LC-3 memory/I-O subsystem: word RAM, keyboard/display registers, program loader.
// Optional define LC3_MCR_EN adds the machine control register at xFFFE.
module lc3_mem_sys #(
  parameter int ADDR_W    = 8,
  parameter bit SKIP_LOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  input  logic        memwe,
  output logic [15:0] memOut,
  output logic        cpu_reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  input  logic        ld_done,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        disp_overrun,
  output logic        halted
);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
`ifdef LC3_MCR_EN
  localparam logic [1:0] HALT = 2'd2;
`endif

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  localparam logic [15:0] KBSR_A = 16'hFE00;
  localparam logic [15:0] KBDR_A = 16'hFE02;
  localparam logic [15:0] DSR_A  = 16'hFE04;
  localparam logic [15:0] DDR_A  = 16'hFE06;
  localparam logic [15:0] MCR_A  = 16'hFFFE;

  logic [1:0]  state;
  logic [15:0] ram [2**ADDR_W];
  logic        kbsr_rdy;
  logic [7:0]  kbdr;
  logic        kbd_prev;

  logic run, core_wr, mar_ram, ld_wr;
  logic kbd_rd, kbd_cap, ddr_wr;

  assign run     = (state == RUN);
  assign core_wr = run & memwe;
  assign mar_ram = ({1'b0, mar} < DEPTH);
  assign ld_wr   = ld_valid & ld_ready & ({1'b0, ld_addr} < DEPTH);
  // A held MAR on KBDR is one read; only the first matching cycle counts.
  assign kbd_rd  = (mar == KBDR_A) & ~kbd_prev;
  assign kbd_cap = run & ~kbsr_rdy & kbd_valid & ~kbd_rd;
  assign ddr_wr  = core_wr & (mar == DDR_A);

  assign ld_ready  = (state == LOAD);
  assign cpu_reset = (state != RUN);
`ifdef LC3_MCR_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SKIP_LOAD ? RUN : LOAD;
    end else if (state == LOAD && ld_done) begin
      state <= RUN;
`ifdef LC3_MCR_EN
    end else if (core_wr && mar == MCR_A && !mdr[15]) begin
      state <= HALT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (ld_wr)
      ram[ld_addr[ADDR_W-1:0]] <= ld_data;
    else if (core_wr && mar_ram)
      ram[mar[ADDR_W-1:0]] <= mdr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbsr_rdy  <= 1'b0;
      kbdr      <= 8'h00;
      kbd_prev  <= 1'b0;
      kbd_ready <= 1'b0;
    end else begin
      kbd_prev  <= (mar == KBDR_A);
      kbd_ready <= kbd_cap;
      if (kbd_rd) begin
        kbsr_rdy <= 1'b0;
      end else if (kbd_cap) begin
        kbsr_rdy <= 1'b1;
        kbdr     <= kbd_data;
      end
    end
  end

  // DSR.ready is simply the complement of disp_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_valid   <= 1'b0;
      disp_data    <= 8'h00;
      disp_overrun <= 1'b0;
    end else begin
      if (disp_valid && disp_ready)
        disp_valid <= 1'b0;
      if (ddr_wr) begin
        if (disp_valid) begin
          disp_overrun <= 1'b1;
        end else begin
          disp_valid <= 1'b1;
          disp_data  <= mdr[7:0];
        end
      end
    end
  end

  always_comb begin
    memOut = 16'h0000;
    unique case (1'b1)
      mar_ram:         memOut = ram[mar[ADDR_W-1:0]];
      (mar == KBSR_A): memOut = {kbsr_rdy, 15'b0};
      (mar == KBDR_A): memOut = {8'h00, kbdr};
      (mar == DSR_A):  memOut = {~disp_valid, 15'b0};
`ifdef LC3_MCR_EN
      (mar == MCR_A):  memOut = {state != HALT, 15'b0};
`endif
      default:         memOut = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_lc3_mem_sys.sv
// Directed bench for lc3_mem_sys with a queue scoreboard.
// Honours LC3_MCR_EN the same way the design does.
module tb_lc3_mem_sys;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mar, mdr;
  logic        memwe;
  logic [15:0] memOut;
  logic        cpu_reset;
  logic        ld_valid, ld_ready;
  logic [15:0] ld_addr, ld_data;
  logic        ld_done;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready;
  logic        disp_overrun;
  logic        halted;

  lc3_mem_sys #(.ADDR_W(8), .SKIP_LOAD(1'b0)) dut (
    .clk(clk), .reset(reset),
    .mar(mar), .mdr(mdr), .memwe(memwe), .memOut(memOut),
    .cpu_reset(cpu_reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .disp_ready(disp_ready), .disp_overrun(disp_overrun),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q [$];
  int total  = 0;
  int passed = 0;
  int kcnt;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  initial begin
    reset = 1'b1; mar = 16'h0; mdr = 16'h0; memwe = 1'b0;
    ld_valid = 1'b0; ld_addr = 16'h0; ld_data = 16'h0; ld_done = 1'b0;
    kbd_valid = 1'b0; kbd_data = 8'h0; disp_ready = 1'b0;
    tick; tick;
    sample;
    push(16'h1); chk("rst_cpu_reset", 16'(cpu_reset));
    push(16'h1); chk("rst_ld_ready", 16'(ld_ready));
    push(16'h0); chk("rst_kbd_ready", 16'(kbd_ready));
    push(16'h0); chk("rst_disp_valid", 16'(disp_valid));
    push(16'h0); chk("rst_disp_data", 16'(disp_data));
    push(16'h0); chk("rst_overrun", 16'(disp_overrun));
    push(16'h0); chk("rst_halted", 16'(halted));
    mar = 16'hFE00; sample;
    push(16'h0000); chk("rst_kbsr", memOut);
    mar = 16'hFE04; sample;
    push(16'h8000); chk("rst_dsr", memOut);

    // loader
    tick; reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 16'h0000; ld_data = 16'h1000;
    tick; ld_addr = 16'h0001; ld_data = 16'h5020;
    tick; ld_addr = 16'h0100; ld_data = 16'hDEAD;
    tick; ld_addr = 16'h0002; ld_data = 16'h2222; ld_done = 1'b1;
    sample;
    push(16'h1); chk("ld_done_cpu_reset", 16'(cpu_reset));
    tick; ld_valid = 1'b0; ld_done = 1'b0;
    sample;
    push(16'h0); chk("run_cpu_reset", 16'(cpu_reset));
    push(16'h0); chk("run_ld_ready", 16'(ld_ready));
    mar = 16'h0001; sample;
    push(16'h5020); chk("rd_0001", memOut);
    mar = 16'h0000; sample;
    push(16'h1000); chk("rd_0000_no_wrap", memOut);
    mar = 16'h0002; sample;
    push(16'h2222); chk("rd_ld_done_word", memOut);
    mar = 16'hC000; sample;
    push(16'h0000); chk("rd_unmapped", memOut);
    mar = 16'h0100; sample;
    push(16'h0000); chk("rd_past_ram", memOut);

    // core store, then loader ignored in RUN
    tick; mar = 16'h0010; mdr = 16'hBEEF; memwe = 1'b1;
    push(16'hBEEF);
    tick; memwe = 1'b0;
    sample; chk("store_0010", memOut);
    ld_valid = 1'b1; ld_addr = 16'h0010; ld_data = 16'h1111;
    tick; ld_valid = 1'b0;
    sample;
    push(16'hBEEF); chk("ld_ignored_run", memOut);

    // keyboard
    mar = 16'h0000;
    kbd_valid = 1'b1; kbd_data = 8'h41;
    kcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i == 1) kbd_valid = 1'b0;
      sample;
      if (kbd_ready) kcnt++;
    end
    push(16'd1); chk("kbd_ready_pulses", 16'(kcnt));
    mar = 16'hFE00; sample;
    push(16'h8000); chk("kbsr_ready", memOut);
    tick; mar = 16'hFE02;
    for (int i = 0; i < 3; i++) begin
      push(16'h0041);
      sample; chk("kbdr_held", memOut);
      tick;
    end
    mar = 16'hFE00; sample;
    push(16'h0000); chk("kbsr_cleared", memOut);

    // display
    tick; mar = 16'hFE06; mdr = 16'h0048; memwe = 1'b1;
    tick; memwe = 1'b0; mar = 16'hFE04;
    sample;
    push(16'h1);    chk("disp_valid_set", 16'(disp_valid));
    push(16'h0048); chk("disp_data", 16'(disp_data));
    push(16'h0000); chk("dsr_busy", memOut);
    push(16'h0);    chk("no_overrun_yet", 16'(disp_overrun));
    mar = 16'hFE06; mdr = 16'h0049; memwe = 1'b1;
    tick; memwe = 1'b0;
    sample;
    push(16'h0048); chk("busy_write_dropped", 16'(disp_data));
    push(16'h1);    chk("overrun_set", 16'(disp_overrun));
    disp_ready = 1'b1;
    tick; disp_ready = 1'b0; mar = 16'hFE04;
    sample;
    push(16'h0);    chk("disp_done", 16'(disp_valid));
    push(16'h8000); chk("dsr_ready_again", memOut);
    mar = 16'hFE06; mdr = 16'h0050; memwe = 1'b1;
    tick;
    mdr = 16'h0051; disp_ready = 1'b1;
    tick; memwe = 1'b0; disp_ready = 1'b0;
    sample;
    push(16'h0);    chk("hs_write_dropped", 16'(disp_valid));
    push(16'h0050); chk("hs_data_kept", 16'(disp_data));
    push(16'h1);    chk("overrun_sticky", 16'(disp_overrun));

    // MCR
    mar = 16'hFFFE; mdr = 16'h8000; memwe = 1'b1;
    tick; memwe = 1'b0;
    sample;
    push(16'h0); chk("mcr_b15_noop", 16'(halted));
    mdr = 16'h0000; memwe = 1'b1;
    tick; memwe = 1'b0;
`ifdef LC3_MCR_EN
    push(16'h1); push(16'h1); push(16'h0000);
`else
    push(16'h0); push(16'h0); push(16'h0000);
`endif
    sample;
    chk("mcr_halted", 16'(halted));
    chk("mcr_cpu_reset", 16'(cpu_reset));
    chk("mcr_read", memOut);
    tick; tick;
`ifdef LC3_MCR_EN
    push(16'h1);
`else
    push(16'h0);
`endif
    sample; chk("halt_holds", 16'(halted));

    // reset mid-transfer: start a display write first
    tick; reset = 1'b0;
`ifndef LC3_MCR_EN
    mar = 16'hFE06; mdr = 16'h005A; memwe = 1'b1;
    tick; memwe = 1'b0;
    sample;
    push(16'h1); chk("pre_reset_pending", 16'(disp_valid));
`endif
    reset = 1'b1;
    tick; reset = 1'b0;
    sample;
    push(16'h0); chk("rst2_disp_valid", 16'(disp_valid));
    push(16'h0); chk("rst2_overrun", 16'(disp_overrun));
    push(16'h1); chk("rst2_cpu_reset", 16'(cpu_reset));
    push(16'h1); chk("rst2_ld_ready", 16'(ld_ready));
    push(16'h0); chk("rst2_halted", 16'(halted));
    mar = 16'hFE02; sample;
    push(16'h0000); chk("rst2_kbdr", memOut);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lc3_mem_sys.md
Name: lc3_mem_sys

Overview:
- Memory and I/O subsystem directly downstream of the LC-3 core's MAR/MDR/memwe outputs. It produces memOut back to the core's MDR.
- Contains a word RAM, the memory-mapped keyboard and display device registers, and a program-loader FSM.
- The loader fills RAM and holds the core in reset until loading completes.

Parameters:
ADDR_W, 8, RAM address width; RAM depth is 2**ADDR_W 16-bit words, mapped at x0000 upward.
SKIP_LOAD, 0, 1 means leave reset directly in RUN, with cpu_reset low and the loader disabled.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mar  in  16  core MAR (registered in the core)
mdr  in  16  core MDR (store data)
memwe  in  1  core memory write enable
memOut  out  16  read data for the core's MDR mux
cpu_reset  out  1  reset to the core; high while loading or halted
ld_valid  in  1  loader word valid
ld_ready  out  1  loader may present a word
ld_addr  in  16  loader target address
ld_data  in  16  loader word
ld_done  in  1  single-cycle pulse: program complete
kbd_valid  in  1  keyboard character available
kbd_data  in  8  keyboard character
kbd_ready  out  1  keyboard character accepted
disp_valid  out  1  display character pending
disp_data  out  8  display character
disp_ready  in  1  display consumed character
disp_overrun  out  1  sticky: DDR write while display busy
halted  out  1  machine halted via MCR

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. All state below updates on posedge clk only.
- Reset values:
  - FSM goes to LOAD, or RUN if SKIP_LOAD=1.
  - cpu_reset=1 in LOAD, 0 in RUN.
  - ld_ready equals (state==LOAD).
  - kbd_ready=0, disp_valid=0, disp_data=0, disp_overrun=0, halted=0.
  - KBSR.ready=0, KBDR=0, DSR.ready=1.
  - RAM contents are not reset.
- Address map (full 16-bit compare):
  - x0000..2**ADDR_W-1: RAM.
  - xFE00: KBSR, bit15=ready.
  - xFE02: KBDR, {8'h0, char}.
  - xFE04: DSR, bit15=ready.
  - xFE06: DDR.
  - Any other address reads x0000 and ignores writes.
- Read path:
  - memOut is combinational from mar, so it is valid in the same cycle the core samples it, one cycle after the core loads MAR.
  - RAM is an asynchronous-read array.
- Write path: when memwe=1 and state==RUN, mdr is written at mar on the clock edge. RAM writes complete in one cycle.
- FSM states: LOAD, RUN, HALT.
  - LOAD:
    - Each cycle with ld_valid&ld_ready, write ld_data to RAM[ld_addr[ADDR_W-1:0]]. ld_addr values at or above the RAM depth are dropped.
    - On ld_done, go to RUN. A write in the same cycle as ld_done is still performed.
    - cpu_reset falls the cycle after ld_done.
  - RUN: core memwe is honoured; ld_valid is ignored.
  - HALT: cpu_reset=1 and halted=1. Only reset exits HALT.
- Core writes are ignored outside RUN.
- Keyboard:
  - In RUN, while KBSR.ready=0 and kbd_valid=1: capture kbd_data into KBDR, set KBSR.ready, and pulse kbd_ready for one cycle.
  - A read of KBDR is detected on the first cycle mar==xFE02, using a registered previous-match flag so that a held MAR counts once. That read clears KBSR.ready on the next edge; KBDR keeps its value.
  - If a capture and a KBDR read occur in the same cycle, the read wins: ready clears and the new character waits for kbd_valid on a later cycle.
- Display:
  - A write to DDR while DSR.ready=1 latches mdr[7:0] into disp_data, sets disp_valid, and clears DSR.ready.
  - disp_valid&disp_ready completes the transfer: disp_valid=0 and DSR.ready=1 on the next edge.
  - A DDR write while DSR.ready=0 is dropped and sets disp_overrun, which is cleared only by reset.
  - A DDR write in the same cycle as the handshake completes is treated as busy and dropped.
- Reset mid-load or mid-transfer: everything returns to the reset values above immediately on that edge. A pending display character is discarded.

Optional Feature:
- Macro: LC3_MCR_EN.
- Defined:
  - Adds the MCR at xFFFE, reset value x8000, read through memOut.
  - A core write with mdr[15]=0 moves the FSM RUN->HALT on that edge; MCR is then x0000.
  - A write with mdr[15]=1 has no effect.
- Undefined:
  - xFFFE behaves as unmapped.
  - halted is tied to 0 and the HALT state is absent.

Test Plan:
- Load: reset, then loader writes x1000=>addr x0000 and x5020=>addr x0001, then ld_done -> cpu_reset=0 one cycle after ld_done; mar=x0001 gives memOut=x5020.
- Out-of-range load and read: ld_addr=x0100 with ADDR_W=8 -> RAM unchanged; in RUN, mar=xC000 gives memOut=x0000.
- Store: RUN, mar=x0010, mdr=xBEEF, memwe=1 for one cycle -> next cycle memOut=xBEEF at mar=x0010.
- Keyboard: kbd_valid with kbd_data=x41 -> kbd_ready pulses once; mar=xFE00 gives memOut=x8000. mar=xFE02 held 3 cycles -> memOut=x0041 throughout; KBSR reads x0000 afterwards.
- Display:
  - DDR write with mdr=x0048 -> disp_valid=1, disp_data=x48, DSR=x0000.
  - A second write before disp_ready -> dropped, disp_overrun=1.
  - Then disp_ready=1 -> DSR=x8000 the next cycle.
- MCR (LC3_MCR_EN defined): write x0000 to xFFFE -> halted=1 and cpu_reset=1 next edge; remains so until reset. With the macro undefined, the same write has no effect.
